// File: rtl/store_write_buffer_pkg.sv
// Shared memory-subsystem types for the store data queue and write buffer.
// Holds sdq_entry_t, the write-buffer depth default and internal types.
package store_write_buffer_pkg;

  localparam int WB_ENTRIES_DEF = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [3:0]  be;
    logic [5:0]  sdq_tag;
  } sdq_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REQ,
    WB_WAIT
  } wb_state_e;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store-issue and memory-write bus of the store write buffer.
// slave: buffer side, master: store data queue / memory side.
interface store_write_buffer_if;
  import store_write_buffer_pkg::*;

  logic        issue_vld_i;
  sdq_entry_t  issue_entry_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_done_i;

  modport slave (
    input  issue_vld_i, issue_entry_i,
    input  mem_gnt_i, mem_done_i,
    output mem_req_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output issue_vld_i, issue_entry_i,
    output mem_gnt_i, mem_done_i,
    input  mem_req_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Write-buffer storage: in-order FIFO with wrap-bit pointers,
// per-entry valid bits and full/empty/count status.
module wb_fifo
  import store_write_buffer_pkg::*;
#(
  parameter  int N  = WB_ENTRIES_DEF,
  localparam int IW = $clog2(N),
  localparam int CW = IW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  wb_entry_t             push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o,
  output wb_entry_t             head_o,
  output wb_entry_t             next_o,
  output wb_entry_t [N-1:0]     mem_o,
  output logic [N-1:0]          vld_o,
  output logic [IW-1:0]         head_idx_o
);

  logic [CW-1:0]     head_q, head_d;
  logic [CW-1:0]     tail_q, tail_d;
  logic [N-1:0]      vld_q, vld_d;
  wb_entry_t [N-1:0] mem_q;
  logic [IW-1:0]     next_idx;
  logic              wr;

  assign full_o  = (head_q[IW-1:0] == tail_q[IW-1:0])
                && (head_q[IW] != tail_q[IW]);
  assign empty_o = (head_q == tail_q);
  assign count_o = tail_q - head_q;
  assign wr      = push_i && !full_o;

  assign head_idx_o = head_q[IW-1:0];
  assign next_idx   = head_q[IW-1:0] + IW'(1);
  assign head_o     = mem_q[head_q[IW-1:0]];
  assign next_o     = mem_q[next_idx];
  assign mem_o      = mem_q;
  assign vld_o      = vld_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    if (wr) begin
      vld_d[tail_q[IW-1:0]] = 1'b1;
      tail_d = tail_q + CW'(1);
    end
    if (pop_i && !empty_o) begin
      vld_d[head_q[IW-1:0]] = 1'b0;
      head_d = head_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[tail_q[IW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of issued stores drained to memory by a
// REQ/WAIT write FSM. Optional load forwarding under STORE_WB_FWD_EN.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter  int WB_ENTRIES = WB_ENTRIES_DEF,
  localparam int IW = $clog2(WB_ENTRIES),
  localparam int CW = IW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  store_write_buffer_if.slave  bus,
  output logic                 wb_full_o,
  output logic                 wb_empty_o,
  output logic [CW-1:0]        wb_count_o,
  output logic                 ovf_o,
  input  logic                 ld_vld_i,
  input  logic [31:0]          ld_addr_i,
  output logic                 ld_hit_o,
  output logic [31:0]          ld_data_o
);

  wb_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ovf_q, ovf_d;
  logic        pop;

  wb_entry_t                  push_data;
  wb_entry_t                  head_ent, next_ent;
  wb_entry_t [WB_ENTRIES-1:0] fwd_mem;
  logic [WB_ENTRIES-1:0]      fwd_vld;
  logic [IW-1:0]              head_idx;
  logic                       unused_sdq;

  assign push_data  = '{addr: bus.issue_entry_i.addr,
                        data: bus.issue_entry_i.store_data};
  assign unused_sdq = ^{bus.issue_entry_i.be,
                        bus.issue_entry_i.sdq_tag};

  wb_fifo #(.N(WB_ENTRIES)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.issue_vld_i),
    .push_data_i (push_data),
    .pop_i       (pop),
    .full_o      (wb_full_o),
    .empty_o     (wb_empty_o),
    .count_o     (wb_count_o),
    .head_o      (head_ent),
    .next_o      (next_ent),
    .mem_o       (fwd_mem),
    .vld_o       (fwd_vld),
    .head_idx_o  (head_idx)
  );

  // full is the registered state, so a same-cycle pop never rescues a push
  assign ovf_d = ovf_q || (bus.issue_vld_i && wb_full_o);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (!wb_empty_o) begin
          state_d = WB_REQ;
          addr_d  = head_ent.addr;
          wdata_d = head_ent.data;
        end
      end
      WB_REQ: begin
        if (bus.mem_gnt_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.mem_done_i) begin
          pop = 1'b1;
          if (wb_count_o > CW'(1)) begin
            state_d = WB_REQ;
            addr_d  = next_ent.addr;
            wdata_d = next_ent.data;
          end else begin
            state_d = WB_IDLE;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mem_req_o   = (state_q == WB_REQ);
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign ovf_o           = ovf_q;

`ifdef STORE_WB_FWD_EN
  logic [IW-1:0] fwd_idx;

  // oldest to youngest, so the last match wins
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    fwd_idx   = head_idx;
    for (int i = 0; i < WB_ENTRIES; i++) begin
      fwd_idx = head_idx + IW'(i);
      if (ld_vld_i && fwd_vld[fwd_idx]
          && fwd_mem[fwd_idx].addr == ld_addr_i) begin
        ld_hit_o  = 1'b1;
        ld_data_o = fwd_mem[fwd_idx].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem, fwd_vld, head_idx,
                        ld_vld_i, ld_addr_i};
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = '0;
`endif

endmodule
